// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the two-port memory arbiter: FSM state encoding
// and port-index constants.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB      = 2'd0,
    LOCK_CPU = 2'd1,
    LOCK_DMA = 2'd2
  } arb_state_e;

  localparam logic CPU = 1'b0;
  localparam logic DMA = 1'b1;

endpackage

// File: rtl/mem_rd_return.sv
// Per-port read-return slice: registers the memory read data on a granted
// read and pulses rvalid for one cycle.
module mem_rd_return (
  input  logic        clk,
  input  logic        rst,
  input  logic        capture,
  input  logic [15:0] rd_data,
  output logic        rvalid,
  output logic [15:0] rdata
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rvalid <= 1'b0;
      rdata  <= '0;
    end else begin
      rvalid <= capture;
      if (capture) rdata <= rd_data;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Zero-latency CPU/DMA arbiter for a single memory port, with round-robin
// tie breaking and bounded locked bursts.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned MAX_BURST = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic        cpu_lock,
  input  logic [15:0] cpu_addr,
  input  logic [15:0] cpu_wd,
  output logic        cpu_gnt,
  output logic        cpu_rvalid,
  output logic [15:0] cpu_rdata,
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic        dma_lock,
  input  logic [15:0] dma_addr,
  input  logic [15:0] dma_wd,
  output logic        dma_gnt,
  output logic        dma_rvalid,
  output logic [15:0] dma_rdata,
  output logic [15:0] m_addr,
  output logic [15:0] m_wd,
  output logic        m_we,
  input  logic [15:0] m_rd
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BURST);
  localparam logic [CNT_W-1:0] ONE_CNT = CNT_W'(1);

  arb_state_e       state, next_state;
  logic             ptr, next_ptr;
  logic [CNT_W-1:0] burst_cnt, next_cnt, cnt_inc;
  logic             cpu_hold, dma_hold;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ARB;
      ptr       <= CPU;
      burst_cnt <= '0;
    end else begin
      state     <= next_state;
      ptr       <= next_ptr;
      burst_cnt <= next_cnt;
    end
  end

  // A held lock keeps ownership; otherwise the cycle falls back to
  // round-robin arbitration, including the cycle a lock is released.
  always_comb begin
    cpu_gnt    = 1'b0;
    dma_gnt    = 1'b0;
    next_state = state;
    next_ptr   = ptr;
    next_cnt   = burst_cnt;
    cnt_inc    = (burst_cnt == MAX_CNT) ? MAX_CNT : burst_cnt + ONE_CNT;
    cpu_hold   = (state == LOCK_CPU) && cpu_req && cpu_lock;
    dma_hold   = (state == LOCK_DMA) && dma_req && dma_lock;

    if (rst) begin
      next_state = ARB;
    end else if (cpu_hold) begin
      cpu_gnt    = 1'b1;
      next_ptr   = DMA;
      next_cnt   = cnt_inc;
      next_state = (cnt_inc >= MAX_CNT) ? ARB : LOCK_CPU;
    end else if (dma_hold) begin
      dma_gnt    = 1'b1;
      next_ptr   = CPU;
      next_cnt   = cnt_inc;
      next_state = (cnt_inc >= MAX_CNT) ? ARB : LOCK_DMA;
    end else begin
      next_state = ARB;
      next_cnt   = '0;
      if (cpu_req && (!dma_req || ptr == CPU)) begin
        cpu_gnt  = 1'b1;
        next_ptr = DMA;
        if (cpu_lock) begin
          next_cnt   = ONE_CNT;
          next_state = (MAX_BURST > 1) ? LOCK_CPU : ARB;
        end
      end else if (dma_req) begin
        dma_gnt  = 1'b1;
        next_ptr = CPU;
        if (dma_lock) begin
          next_cnt   = ONE_CNT;
          next_state = (MAX_BURST > 1) ? LOCK_DMA : ARB;
        end
      end
    end
  end

  always_comb begin
    m_addr = '0;
    m_wd   = '0;
    m_we   = 1'b0;
    if (cpu_gnt) begin
      m_addr = cpu_addr;
      m_wd   = cpu_wd;
      m_we   = cpu_we;
    end else if (dma_gnt) begin
      m_addr = dma_addr;
      m_wd   = dma_wd;
      m_we   = dma_we;
    end
  end

  mem_rd_return u_cpu_ret (
    .clk     (clk),
    .rst     (rst),
    .capture (cpu_gnt && !cpu_we),
    .rd_data (m_rd),
    .rvalid  (cpu_rvalid),
    .rdata   (cpu_rdata)
  );

  mem_rd_return u_dma_ret (
    .clk     (clk),
    .rst     (rst),
    .capture (dma_gnt && !dma_we),
    .rd_data (m_rd),
    .rvalid  (dma_rvalid),
    .rdata   (dma_rdata)
  );

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed scenarios push expected
// grants and read data; a negedge monitor pops and compares.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  typedef struct {
    logic        port;
    logic        we;
    logic [15:0] addr;
    logic [15:0] wd;
  } gnt_rec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        preload = 1'b1;
  logic        cpu_req = 1'b0, cpu_we = 1'b0, cpu_lock = 1'b0;
  logic [15:0] cpu_addr = '0, cpu_wd = '0;
  logic        dma_req = 1'b0, dma_we = 1'b0, dma_lock = 1'b0;
  logic [15:0] dma_addr = '0, dma_wd = '0;
  logic        cpu_gnt, cpu_rvalid, dma_gnt, dma_rvalid, m_we;
  logic [15:0] cpu_rdata, dma_rdata, m_addr, m_wd, m_rd;
  logic [15:0] mem [0:255];

  gnt_rec_t    gnt_q[$];
  logic [15:0] cpu_rd_q[$];
  logic [15:0] dma_rd_q[$];
  int          checks = 0;
  int          errors = 0;

  mem_port_arbiter #(.MAX_BURST(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_lock   (cpu_lock),
    .cpu_addr   (cpu_addr),
    .cpu_wd     (cpu_wd),
    .cpu_gnt    (cpu_gnt),
    .cpu_rvalid (cpu_rvalid),
    .cpu_rdata  (cpu_rdata),
    .dma_req    (dma_req),
    .dma_we     (dma_we),
    .dma_lock   (dma_lock),
    .dma_addr   (dma_addr),
    .dma_wd     (dma_wd),
    .dma_gnt    (dma_gnt),
    .dma_rvalid (dma_rvalid),
    .dma_rdata  (dma_rdata),
    .m_addr     (m_addr),
    .m_wd       (m_wd),
    .m_we       (m_we),
    .m_rd       (m_rd)
  );

  always #5 clk = ~clk;

  // Memory model: address 0x64 holds 0x0001, every other word 0xA000|addr.
  assign m_rd = mem[m_addr[7:0]];
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 256; i++) mem[i] <= (i == 8'h64) ? 16'h0001 : (16'hA000 | 16'(i));
    end else if (m_we) begin
      mem[m_addr[7:0]] <= m_wd;
    end
  end

  task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%04h, expected 0x%04h", name, actual, expected);
    end
  endtask

  task automatic expectGrant(input logic port, input logic we, input logic [15:0] addr, input logic [15:0] wd);
    gnt_rec_t r;
    r.port = port; r.we = we; r.addr = addr; r.wd = wd;
    gnt_q.push_back(r);
  endtask

  // Presents one access on a port and waits (bounded) for its grant; returns
  // just after the grant edge with the request still asserted.
  task automatic applyStimulus(input logic port, input logic we, input logic lock,
                               input logic [15:0] addr, input logic [15:0] wd, output int waited);
    logic granted;
    if (port == CPU) begin
      cpu_req = 1'b1; cpu_we = we; cpu_lock = lock; cpu_addr = addr; cpu_wd = wd;
    end else begin
      dma_req = 1'b1; dma_we = we; dma_lock = lock; dma_addr = addr; dma_wd = wd;
    end
    waited  = 0;
    granted = 1'b0;
    while (!granted && waited < 40) begin
      @(negedge clk);
      granted = (port == CPU) ? cpu_gnt : dma_gnt;
      if (!granted) waited++;
    end
    if (!granted) begin
      checks++;
      errors++;
      $display("[TB] FAIL grant_timeout port %0d: no grant after %0d cycles, expected a grant", port, waited);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic releasePort(input logic port);
    if (port == CPU) begin
      cpu_req = 1'b0; cpu_we = 1'b0; cpu_lock = 1'b0; cpu_addr = '0; cpu_wd = '0;
    end else begin
      dma_req = 1'b0; dma_we = 1'b0; dma_lock = 1'b0; dma_addr = '0; dma_wd = '0;
    end
  endtask

  task automatic doReset();
    releasePort(CPU);
    releasePort(DMA);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("reset_cpu_rvalid", 16'(cpu_rvalid), 16'h0);
    checkOutput("reset_dma_rvalid", 16'(dma_rvalid), 16'h0);
    checkOutput("reset_cpu_rdata", cpu_rdata, 16'h0);
    checkOutput("reset_dma_rdata", dma_rdata, 16'h0);
    checkOutput("reset_state", 16'(dut.state), 16'(ARB));
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Monitor: every grant must match the next queued expectation, every
  // rvalid the next queued read word, and idle cycles must drive zeros.
  always @(negedge clk) begin
    if (rst) begin
      checks++;
      if (cpu_gnt || dma_gnt || m_we) begin
        errors++;
        $display("[TB] FAIL gnt_in_reset: cpu_gnt=%0b dma_gnt=%0b m_we=%0b, expected all 0", cpu_gnt, dma_gnt, m_we);
      end
    end else begin
      if (cpu_gnt || dma_gnt) begin
        checks++;
        if (cpu_gnt && dma_gnt) begin
          errors++;
          $display("[TB] FAIL double_grant: cpu_gnt=1 dma_gnt=1, expected one grant");
        end else if (gnt_q.size() == 0) begin
          errors++;
          $display("[TB] FAIL unexpected_grant: port %0d addr 0x%04h, expected no grant", dma_gnt, m_addr);
        end else begin
          gnt_rec_t r;
          r = gnt_q.pop_front();
          if (dma_gnt !== r.port || m_we !== r.we || m_addr !== r.addr || m_wd !== r.wd) begin
            errors++;
            $display("[TB] FAIL grant: port %0d we %0b addr 0x%04h wd 0x%04h, expected port %0d we %0b addr 0x%04h wd 0x%04h",
                     dma_gnt, m_we, m_addr, m_wd, r.port, r.we, r.addr, r.wd);
          end
        end
      end else begin
        checks++;
        if (m_we !== 1'b0 || m_addr !== 16'h0 || m_wd !== 16'h0) begin
          errors++;
          $display("[TB] FAIL idle_bus: m_we %0b addr 0x%04h wd 0x%04h, expected all 0", m_we, m_addr, m_wd);
        end
      end
      if (cpu_rvalid) begin
        checks++;
        if (cpu_rd_q.size() == 0) begin
          errors++;
          $display("[TB] FAIL cpu_unexpected_rvalid: rdata 0x%04h, expected no rvalid", cpu_rdata);
        end else begin
          logic [15:0] e;
          e = cpu_rd_q.pop_front();
          if (cpu_rdata !== e) begin
            errors++;
            $display("[TB] FAIL cpu_rdata: got 0x%04h, expected 0x%04h", cpu_rdata, e);
          end
        end
      end
      if (dma_rvalid) begin
        checks++;
        if (dma_rd_q.size() == 0) begin
          errors++;
          $display("[TB] FAIL dma_unexpected_rvalid: rdata 0x%04h, expected no rvalid", dma_rdata);
        end else begin
          logic [15:0] e;
          e = dma_rd_q.pop_front();
          if (dma_rdata !== e) begin
            errors++;
            $display("[TB] FAIL dma_rdata: got 0x%04h, expected 0x%04h", dma_rdata, e);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int w, w1, w2;
    logic [15:0] cpu_rd_addr [4];
    logic [15:0] dma_rd_addr [4];
    logic [15:0] cpu_rd_exp  [4];
    logic [15:0] dma_rd_exp  [4];
    cpu_rd_addr = '{16'h0010, 16'h0011, 16'h0012, 16'h0013};
    cpu_rd_exp  = '{16'hA010, 16'hA011, 16'hA012, 16'hA013};
    dma_rd_addr = '{16'h0020, 16'h0021, 16'h0022, 16'h0023};
    dma_rd_exp  = '{16'hA020, 16'hA021, 16'hA022, 16'hA023};

    @(posedge clk);
    #1 preload = 1'b0;

    $display("[TB] CPU-only read");
    doReset();
    expectGrant(CPU, 1'b0, 16'h0064, 16'h0);
    cpu_rd_q.push_back(16'h0001);
    applyStimulus(CPU, 1'b0, 1'b0, 16'h0064, 16'h0, w);
    releasePort(CPU);
    checkOutput("cpu_read_grant_latency", 16'(w), 16'h0);
    @(negedge clk);
    checkOutput("cpu_read_rvalid_next", 16'(cpu_rvalid), 16'h1);
    checkOutput("cpu_read_rdata_next", cpu_rdata, 16'h0001);
    @(posedge clk);
    #1;

    $display("[TB] Round-robin alternation");
    doReset();
    for (int i = 0; i < 4; i++) begin
      expectGrant(CPU, 1'b0, cpu_rd_addr[i], 16'h0);
      expectGrant(DMA, 1'b0, dma_rd_addr[i], 16'h0);
      cpu_rd_q.push_back(cpu_rd_exp[i]);
      dma_rd_q.push_back(dma_rd_exp[i]);
    end
    fork
      begin
        for (int i = 0; i < 4; i++) applyStimulus(CPU, 1'b0, 1'b0, cpu_rd_addr[i], 16'h0, w1);
        releasePort(CPU);
      end
      begin
        for (int i = 0; i < 4; i++) applyStimulus(DMA, 1'b0, 1'b0, dma_rd_addr[i], 16'h0, w2);
        releasePort(DMA);
      end
    join
    repeat (2) @(posedge clk);
    #1;

    $display("[TB] DMA locked burst of 12 with CPU contention");
    doReset();
    for (int i = 0; i < 8; i++) expectGrant(DMA, 1'b1, 16'h0070 + 16'(i), 16'hD000 + 16'(i));
    expectGrant(CPU, 1'b0, 16'h0064, 16'h0);
    for (int i = 8; i < 12; i++) expectGrant(DMA, 1'b1, 16'h0070 + 16'(i), 16'hD000 + 16'(i));
    cpu_rd_q.push_back(16'h0001);
    fork
      begin
        for (int i = 0; i < 12; i++) applyStimulus(DMA, 1'b1, 1'b1, 16'h0070 + 16'(i), 16'hD000 + 16'(i), w1);
        releasePort(DMA);
      end
      begin
        @(posedge clk);
        #1;
        applyStimulus(CPU, 1'b0, 1'b0, 16'h0064, 16'h0, w2);
        releasePort(CPU);
        checkOutput("cpu_wait_for_burst_cap", 16'(w2), 16'h7);
      end
    join
    @(posedge clk);
    #1;
    for (int i = 0; i < 12; i++) checkOutput($sformatf("burst_mem_word_%0d", i), mem[8'h70 + i], 16'hD000 + 16'(i));

    $display("[TB] DMA lock released by dropping req");
    doReset();
    for (int i = 0; i < 3; i++) expectGrant(DMA, 1'b1, 16'h0080 + 16'(i), 16'hB000 + 16'(i));
    expectGrant(CPU, 1'b0, 16'h0010, 16'h0);
    cpu_rd_q.push_back(16'hA010);
    fork
      begin
        for (int i = 0; i < 3; i++) applyStimulus(DMA, 1'b1, 1'b1, 16'h0080 + 16'(i), 16'hB000 + 16'(i), w1);
        releasePort(DMA);
      end
      begin
        @(posedge clk);
        #1;
        applyStimulus(CPU, 1'b0, 1'b0, 16'h0010, 16'h0, w2);
        releasePort(CPU);
        checkOutput("cpu_wait_lock_release", 16'(w2), 16'h2);
        checkOutput("state_after_release", 16'(dut.state), 16'(ARB));
      end
    join
    @(posedge clk);
    #1;

    $display("[TB] Reset during DMA burst");
    doReset();
    for (int i = 0; i < 3; i++) expectGrant(DMA, 1'b1, 16'h0090 + 16'(i), 16'hC000 + 16'(i));
    for (int i = 0; i < 3; i++) applyStimulus(DMA, 1'b1, 1'b1, 16'h0090 + 16'(i), 16'hC000 + 16'(i), w);
    dma_addr = 16'h0093;
    dma_wd   = 16'hC003;
    #1 rst = 1'b1;
    @(negedge clk);
    checkOutput("mid_burst_reset_dma_gnt", 16'(dma_gnt), 16'h0);
    checkOutput("mid_burst_reset_cpu_gnt", 16'(cpu_gnt), 16'h0);
    checkOutput("mid_burst_reset_m_we", 16'(m_we), 16'h0);
    checkOutput("mid_burst_reset_state", 16'(dut.state), 16'(ARB));
    @(posedge clk);
    #1;
    checkOutput("mid_burst_reset_no_write", mem[8'h93], 16'hA093);
    rst = 1'b0;
    expectGrant(CPU, 1'b0, 16'h0064, 16'h0);
    expectGrant(DMA, 1'b1, 16'h0093, 16'hC003);
    cpu_rd_q.push_back(16'h0001);
    fork
      begin
        applyStimulus(CPU, 1'b0, 1'b0, 16'h0064, 16'h0, w1);
        releasePort(CPU);
      end
      begin
        applyStimulus(DMA, 1'b1, 1'b0, 16'h0093, 16'hC003, w2);
        releasePort(DMA);
      end
    join
    checkOutput("cpu_first_tie_after_reset", 16'(w1), 16'h0);
    checkOutput("dma_second_after_reset", 16'(w2), 16'h1);
    @(posedge clk);
    #1;

    $display("[TB] CPU write then read back");
    doReset();
    expectGrant(CPU, 1'b1, 16'h0002, 16'h0037);
    applyStimulus(CPU, 1'b1, 1'b0, 16'h0002, 16'h0037, w);
    releasePort(CPU);
    @(negedge clk);
    checkOutput("no_rvalid_on_write", 16'(cpu_rvalid), 16'h0);
    @(posedge clk);
    #1;
    expectGrant(CPU, 1'b0, 16'h0002, 16'h0);
    cpu_rd_q.push_back(16'h0037);
    applyStimulus(CPU, 1'b0, 1'b0, 16'h0002, 16'h0, w);
    releasePort(CPU);
    @(negedge clk);
    checkOutput("readback_rvalid", 16'(cpu_rvalid), 16'h1);
    checkOutput("readback_rdata", cpu_rdata, 16'h0037);

    repeat (3) @(negedge clk);
    checkOutput("grant_queue_drained", 16'(gnt_q.size()), 16'h0);
    checkOutput("cpu_read_queue_drained", 16'(cpu_rd_q.size()), 16'h0);
    checkOutput("dma_read_queue_drained", 16'(dma_rd_q.size()), 16'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter MAX_BURST, default 8, meaning the maximum number of consecutive locked beats granted to one port.
REQ-002 SHALL have port clk, input, 1, system clock; all state updates on rising edge.
REQ-003 SHALL have port rst, input, 1, reset, asynchronous, active-high.
REQ-004 SHALL have ports cpu_req, cpu_we, cpu_lock, input, 1 each: CPU access request, write enable, hold-ownership request.
REQ-005 SHALL have ports cpu_addr, cpu_wd, input, 16 each: CPU word address and write data.
REQ-006 SHALL have ports cpu_gnt, output, 1, and cpu_rvalid, output, 1: CPU access accepted this cycle; CPU read data valid.
REQ-007 SHALL have port cpu_rdata, output, 16, registered CPU read data.
REQ-008 SHALL have ports dma_req, dma_we, dma_lock, dma_addr[15:0], dma_wd[15:0], dma_gnt, dma_rvalid and dma_rdata[15:0], with the same directions, widths and meanings as the CPU port.
REQ-009 SHALL have ports m_addr, m_wd, output, 16 each, and m_we, output, 1: unified memory address, write data and write enable.
REQ-010 SHALL have port m_rd, input, 16: unified memory read data, combinationally valid in the same cycle as m_addr.

Function
REQ-011 SHALL grant at most one port per cycle; cpu_gnt and dma_gnt SHALL never both be 1.
REQ-012 SHALL compute the grant combinationally from the req inputs, the FSM state and the round-robin pointer; the access completes in the grant cycle, with zero arbitration latency.
REQ-013 SHALL accept a transaction when req=1 and gnt=1; the requester holds addr, wd, we and lock stable while req=1 and gnt=0.
REQ-014 SHALL drive m_addr, m_wd and m_we from the granted port, with m_we = granted we; with no grant, m_we=0, m_addr=0 and m_wd=0.
REQ-015 SHALL, for a granted read, capture m_rd into that port's rdata at the grant-cycle edge and pulse that port's rvalid for exactly 1 cycle (read latency 1); rdata SHALL hold its value until the next read by the same port.
REQ-016 SHALL implement FSM states ARB, LOCK_CPU and LOCK_DMA.
REQ-017 In ARB with a single requester, that requester SHALL win.
REQ-018 In ARB with both ports requesting, the port not granted most recently SHALL win; the pointer updates on every grant.
REQ-019 ARB SHALL transition to LOCK_x when port x is granted with lock_x=1; the burst counter SHALL load 1.
REQ-020 In LOCK_x with req_x=1, port x SHALL be granted unconditionally, the other port's req is ignored, and the burst counter increments.
REQ-021 In LOCK_x, when req_x=0 or lock_x=0, ownership SHALL release: that cycle is arbitrated by ARB rules and the FSM follows the ARB transitions.
REQ-022 When the burst counter reaches MAX_BURST on a grant, the next state SHALL be ARB and the pointer SHALL favour the other port, even if lock_x is still 1.
REQ-023 The burst counter SHALL be $clog2(MAX_BURST+1) bits wide and SHALL never wrap.
REQ-024 A port's write access SHALL never assert that port's rvalid.

Reset
REQ-025 On rst=1 the block SHALL immediately set state=ARB, pointer favouring CPU, burst counter=0, cpu_rvalid=dma_rvalid=0 and cpu_rdata=dma_rdata=0.
REQ-026 While rst=1, all gnt outputs and m_we SHALL be 0.
REQ-027 A reset asserted mid-burst SHALL abandon the burst with no further grants.

Structure
REQ-028 The FSM state encoding (ARB, LOCK_CPU, LOCK_DMA) and the port-index constants (CPU=0, DMA=1) SHALL reside in the shared processor package.
REQ-029 The block SHALL be a single module with no sub-modules; one per-port read-return register slice MAY be factored out as mem_rd_return.

Verification
REQ-030 Bench SHALL check: CPU-only read of addr 0x0064 with mem=0x0001 -> cpu_gnt=1 the same cycle; next cycle cpu_rvalid=1 and cpu_rdata=0x0001.
REQ-031 Bench SHALL check: both ports request continuously with no lock -> grants alternate CPU, DMA, CPU, DMA, ..., with CPU first after reset.
REQ-032 Bench SHALL check: DMA locked write burst of 12 words to 0x0070.. while CPU requests -> exactly 8 consecutive dma_gnt, then 1 cpu_gnt, then DMA resumes; memory holds all 12 words.
REQ-033 Bench SHALL check: DMA lock with dma_req dropped after 3 beats -> the CPU is granted in the same cycle and the state returns to ARB.
REQ-034 Bench SHALL check: rst asserted during beat 4 of a DMA burst -> gnt=0 and m_we=0 immediately; after release, the CPU wins the first tie.
REQ-035 Bench SHALL check: CPU write of 0x0037 to 0x0002, then CPU read of 0x0002 -> cpu_rvalid=1 with cpu_rdata=0x0037, and no rvalid pulse on the write.
